// File: rtl/kvs_key_extractor_pkg.sv
// Shared definitions for the KVS flow-key extractor and the database block that consumes its keys.
// Holds the key layout, flag bit positions and protocol constants.
package kvs_pkg;

  localparam int KEY_SIZE  = 96;
  localparam int FLAG_SIZE = 4;

  localparam int FLAG_TCP    = 0;
  localparam int FLAG_UDP    = 1;
  localparam int FLAG_SYN    = 2;
  localparam int FLAG_FINRST = 3;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_TCP   = 8'd6;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'd17;
  localparam logic [7:0]  IPV4_VER_IHL5  = 8'h45;

  // Beat index (64-bit beats) carrying the TCP flags byte; last header beat.
  localparam logic [2:0] LAST_HDR_BEAT = 3'd5;

  typedef struct packed {
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] sport;
    logic [15:0] dport;
  } kvs_key_t;

  typedef enum logic {
    ST_HDR  = 1'b0,
    ST_SKIP = 1'b1
  } kvs_state_e;

  function automatic logic [7:0] beat_byte(input logic [63:0] data, input logic [2:0] idx);
    return data[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/kvs_key_extractor_if.sv
// AXI-Stream tap carrying MAC receive frames into the key extractor.
// The extractor only observes the stream, so there is no tready.
interface kvs_key_extractor_if #(
  parameter int C_DATA_WIDTH = 64
);
  logic [C_DATA_WIDTH-1:0]   tdata;
  logic [C_DATA_WIDTH/8-1:0] tkeep;
  logic                      tvalid;
  logic                      tlast;
  logic                      tuser;

  modport master (output tdata, tkeep, tvalid, tlast, tuser);
  modport slave  (input  tdata, tkeep, tvalid, tlast, tuser);
endinterface

// File: rtl/kvs_key_extractor.sv
// Parses Ethernet/IPv4/TCP|UDP headers off the receive stream and emits one 96-bit
// flow key plus protocol flags per qualifying frame, with frame statistics.
//
// state | meaning
// HDR   | header beats 0..5: capture key fields, clear qualify on any failed check
// SKIP  | header done, waiting for tlast of the current frame
module kvs_key_extractor
  import kvs_pkg::*;
#(
  parameter int KEY_SIZE     = 96,
  parameter int FLAG_SIZE    = 4,
  parameter int C_DATA_WIDTH = 64,
  parameter int STAT_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  kvs_key_extractor_if.slave     s_axis,
  output logic [KEY_SIZE-1:0]    key_data,
  output logic [FLAG_SIZE-1:0]   key_flag,
  output logic                   key_valid,
  output logic [STAT_WIDTH-1:0]  stat_frames,
  output logic [STAT_WIDTH-1:0]  stat_keys,
  output logic [STAT_WIDTH-1:0]  stat_skipped
);

  localparam logic [STAT_WIDTH-1:0] STAT_ONE = {{(STAT_WIDTH-1){1'b0}}, 1'b1};

  kvs_state_e     state_q, state_d;
  logic [2:0]     beat_q, beat_d;
  logic           qual_q, qual_d;
  logic           is_tcp_q, is_tcp_d;
  kvs_key_t       key_acc_q, key_acc_d;

  logic           emit;
  logic           frame_end;
  logic           skip_inc;
  logic [3:0]     flag_nxt;

  logic [63:0]    d;
  logic           beat;
  logic [15:0]    word_45;
  logic [7:0]     byte_6;
  logic [7:0]     byte_7;
  logic           unused_inputs;

  assign d       = s_axis.tdata;
  assign beat    = s_axis.tvalid;
  assign word_45 = {beat_byte(d, 3'd4), beat_byte(d, 3'd5)};
  assign byte_6  = beat_byte(d, 3'd6);
  assign byte_7  = beat_byte(d, 3'd7);

  // tkeep and tuser do not influence key extraction; FCS filtering happens downstream.
  assign unused_inputs = ^{s_axis.tkeep, s_axis.tuser, d};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_HDR;
      beat_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    case (state_q)
      ST_HDR: begin
        if (beat) begin
          if (s_axis.tlast) begin
            state_d = ST_HDR;
            beat_d  = 3'd0;
          end else if (beat_q == LAST_HDR_BEAT) begin
            state_d = ST_SKIP;
            beat_d  = 3'd0;
          end else begin
            beat_d = beat_q + 3'd1;
          end
        end
      end
      ST_SKIP: begin
        if (beat && s_axis.tlast) begin
          state_d = ST_HDR;
          beat_d  = 3'd0;
        end
      end
      default: begin
        state_d = ST_HDR;
        beat_d  = 3'd0;
      end
    endcase
  end

  always_comb begin
    emit      = 1'b0;
    skip_inc  = 1'b0;
    frame_end = beat && s_axis.tlast;
    if (beat) begin
      case (state_q)
        ST_HDR: begin
          if (beat_q == LAST_HDR_BEAT) begin
            emit     = qual_q;
            skip_inc = s_axis.tlast && !qual_q;
          end else begin
            skip_inc = s_axis.tlast;
          end
        end
        ST_SKIP: skip_inc = s_axis.tlast && !qual_q;
        default: skip_inc = 1'b0;
      endcase
    end
    flag_nxt              = 4'b0000;
    flag_nxt[FLAG_TCP]    = is_tcp_q;
    flag_nxt[FLAG_UDP]    = !is_tcp_q;
    flag_nxt[FLAG_SYN]    = is_tcp_q && byte_7[1] && !byte_7[4];
    flag_nxt[FLAG_FINRST] = is_tcp_q && (byte_7[0] || byte_7[2]);
  end

  // Field capture; qualify is only consulted at beat 5 so checks can fail on any earlier beat.
  always_comb begin
    qual_d    = qual_q;
    is_tcp_d  = is_tcp_q;
    key_acc_d = key_acc_q;
    if (state_q == ST_HDR && beat) begin
      case (beat_q)
        3'd0: qual_d = 1'b1;
        3'd1: begin
          if (word_45 != ETHERTYPE_IPV4 || byte_6 != IPV4_VER_IHL5) qual_d = 1'b0;
        end
        3'd2: begin
          is_tcp_d = (byte_7 == IP_PROTO_TCP);
          if (word_45[13:0] != 14'd0) qual_d = 1'b0;
          if (byte_7 != IP_PROTO_TCP && byte_7 != IP_PROTO_UDP) qual_d = 1'b0;
        end
        3'd3: begin
          key_acc_d.src_ip         = {beat_byte(d, 3'd2), beat_byte(d, 3'd3), word_45};
          key_acc_d.dst_ip[31:16]  = {byte_6, byte_7};
        end
        3'd4: begin
          key_acc_d.dst_ip[15:0] = {beat_byte(d, 3'd0), beat_byte(d, 3'd1)};
          key_acc_d.sport        = {beat_byte(d, 3'd2), beat_byte(d, 3'd3)};
          key_acc_d.dport        = word_45;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      qual_q    <= 1'b0;
      is_tcp_q  <= 1'b0;
      key_acc_q <= '0;
    end else begin
      qual_q    <= qual_d;
      is_tcp_q  <= is_tcp_d;
      key_acc_q <= key_acc_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_data     <= '0;
      key_flag     <= '0;
      key_valid    <= 1'b0;
      stat_frames  <= '0;
      stat_keys    <= '0;
      stat_skipped <= '0;
    end else begin
      key_valid <= emit;
      if (emit) begin
        key_data  <= key_acc_q;
        key_flag  <= flag_nxt;
        stat_keys <= stat_keys + STAT_ONE;
      end
      if (frame_end) stat_frames  <= stat_frames + STAT_ONE;
      if (skip_inc)  stat_skipped <= stat_skipped + STAT_ONE;
    end
  end

endmodule

// File: tb/tb_kvs_key_extractor.sv
// Self-checking bench for kvs_key_extractor: frame-level reference model with an event
// queue timed to beat handshakes, directed frames from the test plan plus random traffic.
module tb_kvs_key_extractor;

  logic        clk;
  logic        rst;
  logic [95:0] key_data;
  logic [3:0]  key_flag;
  logic        key_valid;
  logic [31:0] stat_frames, stat_keys, stat_skipped;

  kvs_key_extractor_if #(.C_DATA_WIDTH(64)) axis_if ();

  kvs_key_extractor dut (
    .clk          (clk),
    .rst          (rst),
    .s_axis       (axis_if),
    .key_data     (key_data),
    .key_flag     (key_flag),
    .key_valid    (key_valid),
    .stat_frames  (stat_frames),
    .stat_keys    (stat_keys),
    .stat_skipped (stat_skipped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {EV_KEY, EV_FRAME, EV_SKIP} ev_kind_e;
  typedef struct {
    longint      at_edge;
    ev_kind_e    kind;
    logic [95:0] key;
    logic [3:0]  flag;
  } ev_t;

  ev_t         evq[$];
  longint      edge_cnt = 0;
  int          n_checks = 0;
  int          n_err    = 0;
  int          m_frames, m_keys, m_skipped;
  logic [7:0]  fb [0:255];
  int          flen;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare process: retire model events due at this edge, then check every output.
  always @(negedge clk) begin
    logic        exp_kv;
    logic [95:0] ek;
    logic [3:0]  ef;
    ev_t         e;
    exp_kv = 1'b0;
    ek = '0;
    ef = '0;
    while (evq.size() > 0 && evq[0].at_edge <= edge_cnt) begin
      e = evq.pop_front();
      case (e.kind)
        EV_KEY:   begin exp_kv = 1'b1; ek = e.key; ef = e.flag; m_keys++; end
        EV_FRAME: m_frames++;
        default:  m_skipped++;
      endcase
    end
    check("key_valid", {95'd0, key_valid}, {95'd0, exp_kv});
    if (exp_kv) begin
      check("key_data", key_data, ek);
      check("key_flag", {92'd0, key_flag}, {92'd0, ef});
    end
    check("stat_frames", {64'd0, stat_frames}, 96'(m_frames));
    check("stat_keys", {64'd0, stat_keys}, 96'(m_keys));
    check("stat_skipped", {64'd0, stat_skipped}, 96'(m_skipped));
  end

  function automatic void clear_model();
    evq.delete();
    m_frames  = 0;
    m_keys    = 0;
    m_skipped = 0;
  endfunction

  function automatic void build_frame(input int len, input logic [15:0] eth, input logic [7:0] verihl,
                                      input logic [15:0] frag, input logic [7:0] proto,
                                      input logic [31:0] sip, input logic [31:0] dip,
                                      input logic [15:0] sp, input logic [15:0] dp,
                                      input logic [7:0] tflags);
    for (int i = 0; i < 256; i++) fb[i] = 8'($urandom);
    flen = len;
    {fb[12], fb[13]} = eth;
    fb[14] = verihl;
    {fb[20], fb[21]} = frag;
    fb[23] = proto;
    {fb[26], fb[27], fb[28], fb[29]} = sip;
    {fb[30], fb[31], fb[32], fb[33]} = dip;
    {fb[34], fb[35]} = sp;
    {fb[36], fb[37]} = dp;
    fb[47] = tflags;
  endfunction

  // Frame-level reference: a key exists iff the frame reaches beat 5 and every header rule holds.
  function automatic void model_eval(output logic has_key, output logic [95:0] k, output logic [3:0] f);
    int          nb;
    logic [15:0] et, fr;
    logic [7:0]  pr, tf;
    nb = (flen + 7) / 8;
    et = {fb[12], fb[13]};
    fr = {fb[20], fb[21]};
    pr = fb[23];
    tf = fb[47];
    has_key = (nb >= 6) && (et == 16'h0800) && (fb[14] == 8'h45) && (fr[13:0] == 14'd0) &&
              (pr == 8'd6 || pr == 8'd17);
    k = {fb[26], fb[27], fb[28], fb[29], fb[30], fb[31], fb[32], fb[33],
         fb[34], fb[35], fb[36], fb[37]};
    if (pr == 8'd6) f = {tf[0] | tf[2], tf[1] & ~tf[4], 1'b0, 1'b1};
    else            f = 4'b0010;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      axis_if.tvalid = 1'b0;
      axis_if.tlast  = 1'($urandom);
      axis_if.tdata  = {$urandom, $urandom};
      axis_if.tkeep  = 8'($urandom);
      axis_if.tuser  = 1'($urandom);
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    axis_if.tvalid = 1'b0;
    clear_model();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
  endtask

  // gap < 0 picks a random 0..2 idle cycles between beats; abort_beat >= 0 pulls reset on that beat.
  task automatic send_frame(input int gap, input int abort_beat);
    int          nb, rem, g;
    logic        hk;
    logic [95:0] k;
    logic [3:0]  f;
    ev_t         e;
    longint      ke;
    nb = (flen + 7) / 8;
    model_eval(hk, k, f);
    for (int b = 0; b < nb; b++) begin
      if (b > 0) begin
        g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
        idle(g);
      end
      @(posedge clk); #1;
      ke = edge_cnt + 1;
      for (int i = 0; i < 8; i++) axis_if.tdata[8*i +: 8] = fb[8*b + i];
      rem = flen - 8*b;
      axis_if.tkeep  = (rem >= 8) ? 8'hFF : 8'((1 << rem) - 1);
      axis_if.tvalid = 1'b1;
      axis_if.tlast  = (b == nb - 1);
      axis_if.tuser  = (b == nb - 1) ? 1'($urandom) : 1'b0;
      if (b == abort_beat) begin
        rst = 1'b0;
        clear_model();
        @(posedge clk); #1;
        axis_if.tvalid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        return;
      end
      if (b == 5 && hk) begin
        e.at_edge = ke; e.kind = EV_KEY; e.key = k; e.flag = f;
        evq.push_back(e);
      end
      if (b == nb - 1) begin
        e.at_edge = ke; e.kind = EV_FRAME; e.key = '0; e.flag = '0;
        evq.push_back(e);
        if (!hk) begin
          e.kind = EV_SKIP;
          evq.push_back(e);
        end
      end
    end
  endtask

  initial begin
    logic        hk;
    logic [95:0] k;
    logic [3:0]  f;
    int          len;
    logic [15:0] eth, frag;
    logic [7:0]  vih, pr;
    rst = 1'b0;
    axis_if.tvalid = 1'b0;
    axis_if.tlast  = 1'b0;
    axis_if.tdata  = '0;
    axis_if.tkeep  = '0;
    axis_if.tuser  = 1'b0;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    check("reset key_data", key_data, 96'd0);
    check("reset key_valid", {95'd0, key_valid}, 96'd0);
    rst = 1'b1;
    idle(2);

    // TCP SYN, 64 bytes
    build_frame(64, 16'h0800, 8'h45, 16'h4000, 8'd6, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd80, 8'h02);
    model_eval(hk, k, f);
    check("model tcp key", k, 96'h0A000001_0A000002_04D2_0050);
    check("model tcp flag", {92'd0, f}, {92'd0, 4'b0101});
    send_frame(0, -1);
    idle(3);
    check("tcp syn key_data", key_data, 96'h0A000001_0A000002_04D2_0050);
    check("tcp syn stat_keys", {64'd0, stat_keys}, 96'd1);

    // UDP, 60 bytes, 3-cycle gaps between beats
    pulse_reset();
    build_frame(60, 16'h0800, 8'h45, 16'h0000, 8'd17, 32'hC0A80105, 32'hC0A80109, 16'd53, 16'd4000, 8'h00);
    send_frame(3, -1);
    idle(3);
    check("udp key_data", key_data, 96'hC0A80105_C0A80109_0035_0FA0);

    // ARP
    pulse_reset();
    build_frame(60, 16'h0806, 8'h45, 16'h0000, 8'd6, 32'h1, 32'h2, 16'd3, 16'd4, 8'h02);
    send_frame(0, -1);
    idle(3);
    check("arp stat_skipped", {64'd0, stat_skipped}, 96'd1);
    check("arp stat_frames", {64'd0, stat_frames}, 96'd1);
    check("arp stat_keys", {64'd0, stat_keys}, 96'd0);

    // Truncated 32B then back-to-back TCP ACK+FIN
    pulse_reset();
    build_frame(32, 16'h0800, 8'h45, 16'h0000, 8'd6, 32'h01020304, 32'h05060708, 16'd1, 16'd2, 8'h02);
    send_frame(0, -1);
    build_frame(64, 16'h0800, 8'h45, 16'h0000, 8'd6, 32'h0B0C0D0E, 32'h0F101112, 16'd5000, 16'd443, 8'h11);
    model_eval(hk, k, f);
    check("model ackfin flag", {92'd0, f}, {92'd0, 4'b1001});
    send_frame(0, -1);
    idle(3);
    check("b2b stat_frames", {64'd0, stat_frames}, 96'd2);
    check("b2b stat_skipped", {64'd0, stat_skipped}, 96'd1);
    check("b2b key_data", key_data, 96'h0B0C0D0E_0F101112_1388_01BB);

    // Fragment and IHL=6
    pulse_reset();
    build_frame(64, 16'h0800, 8'h45, 16'h2000, 8'd6, 32'h1, 32'h2, 16'd3, 16'd4, 8'h02);
    send_frame(0, -1);
    build_frame(64, 16'h0800, 8'h46, 16'h0000, 8'd17, 32'h1, 32'h2, 16'd3, 16'd4, 8'h00);
    send_frame(1, -1);
    idle(3);
    check("frag/ihl stat_skipped", {64'd0, stat_skipped}, 96'd2);
    check("frag/ihl stat_keys", {64'd0, stat_keys}, 96'd0);

    // Reset during beat 4, then a clean UDP frame
    pulse_reset();
    build_frame(64, 16'h0800, 8'h45, 16'h0000, 8'd6, 32'hAA000001, 32'hAA000002, 16'd7, 16'd8, 8'h02);
    send_frame(0, 4);
    idle(1);
    build_frame(60, 16'h0800, 8'h45, 16'h0000, 8'd17, 32'hC0A80105, 32'hC0A80109, 16'd53, 16'd4000, 8'h00);
    send_frame(0, -1);
    idle(3);
    check("post-reset stat_frames", {64'd0, stat_frames}, 96'd1);
    check("post-reset key_data", key_data, 96'hC0A80105_C0A80109_0035_0FA0);

    // Random traffic, including 48-byte frames, short frames and back-to-back frames
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 3) == 0) len = int'($urandom_range(14, 40));
      else if ($urandom_range(0, 5) == 0) len = 48;
      else len = int'($urandom_range(48, 128));
      eth  = ($urandom_range(0, 9) < 8) ? 16'h0800 : 16'($urandom);
      vih  = ($urandom_range(0, 9) < 9) ? 8'h45 : 8'($urandom);
      frag = ($urandom_range(0, 9) < 8) ? (($urandom_range(0, 1) == 1) ? 16'h4000 : 16'h0000) : 16'($urandom);
      case ($urandom_range(0, 9))
        0:       pr = 8'($urandom);
        1, 2, 3, 4: pr = 8'd17;
        default: pr = 8'd6;
      endcase
      build_frame(len, eth, vih, frag, pr, $urandom, $urandom, 16'($urandom), 16'($urandom), 8'($urandom));
      send_frame(($urandom_range(0, 1) == 1) ? -1 : 0, -1);
      idle(int'($urandom_range(0, 2)));
    end
    idle(4);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/kvs_key_extractor.md
Name: kvs_key_extractor

Overview:
- Receive-side parser that feeds the KVS lookup path of the database block.
- Taps the 64-bit AXI-Stream frame from the 10G MAC on db_clk.
- Parses Ethernet/IPv4/TCP|UDP headers and emits one 96-bit flow key plus a 4-bit flag per qualifying frame, as a single-cycle valid pulse.
- Monitor-only: the stream is never back-pressured. Frame counters are exposed for debug LEDs.

Parameters:
- KEY_SIZE, 96, key width {src_ip[31:0], dst_ip[31:0], sport[15:0], dport[15:0]}; fixed by layout, must be 96.
- FLAG_SIZE, 4, flag width.
- C_DATA_WIDTH, 64, stream width; only 64 supported.
- STAT_WIDTH, 32, width of each statistics counter.

Ports:
- clk  input  1  db_clk domain clock.
- rst  input  1  asynchronous, active-low reset.
- s_axis_tdata  input  64  frame data; wire byte n of a beat is tdata[8n+7:8n].
- s_axis_tkeep  input  8  byte enables; only meaningful on the tlast beat.
- s_axis_tvalid  input  1  beat valid.
- s_axis_tlast  input  1  last beat of frame.
- s_axis_tuser  input  1  MAC error flag, sampled on the tlast beat.
- key_data  output  96  extracted key, network byte order (src_ip[31:24] = frame byte 26).
- key_flag  output  4  [0] TCP, [1] UDP, [2] TCP SYN=1 and ACK=0, [3] TCP FIN or RST.
- key_valid  output  1  one-cycle pulse; key_data and key_flag are valid only while it is high.
- stat_frames  output  32  count of tlast beats seen.
- stat_keys  output  32  count of key_valid pulses.
- stat_skipped  output  32  frames finished without a key (short, non-IPv4, IHL≠5, fragment, non-TCP/UDP).

Behaviour:
- Reset (rst=0, async): key_data=0, key_flag=0, key_valid=0, all stats=0, FSM=HDR, beat count=0.
  - Upstream MAC is held in reset with this block, so the first beat after release is treated as beat 0.
- Beat count advances only on tvalid. Idle gaps mid-frame are legal and change nothing.
- FSM states:
  - HDR (beats 0..5): capture fields and latch checks.
  - SKIP: wait for tlast.
- Byte capture, beat index b covers frame bytes 8b..8b+7:
  - b1: ethertype bytes 12-13 must be 0x0800; ver/IHL byte 14 must be 0x45.
  - b2: flags/frag bytes 20-21 must satisfy (MF=0 and offset=0); proto byte 23 is 6 (TCP) or 17 (UDP).
  - b3: src_ip bytes 26-29; dst_ip[31:16] bytes 30-31.
  - b4: dst_ip[15:0] bytes 32-33; sport bytes 34-35; dport bytes 36-37.
  - b5: TCP flags byte 47 (FIN bit0, SYN bit1, RST bit2, ACK bit4).
- A failed check clears a "qualify" bit, but the FSM stays in HDR until b5 or tlast. This keeps the skip decision uniform.
- b5 accepted with qualify=1: the next cycle drives key_valid=1 with registered key_data/key_flag, and stat_keys increments. UDP sets flag 4'b0010; bits [3:2] apply to TCP only.
- After b5 without tlast, the FSM goes to SKIP. b5 carrying tlast (48-byte frame) returns to HDR with count 0.
- tlast on b0..b4: no key, stat_skipped+1, back to HDR.
- b5 with qualify=0: stat_skipped+1 at that frame's tlast.
- Every tlast beat increments stat_frames, in any state, including b5.
- Fixed latency: key_valid is asserted exactly 1 cycle after the b5 beat handshake. key_data holds its value until the next key.
- tuser=1 does not suppress a key that was already emitted. Filtering on FCS errors is the responsibility of the database block.
- Counters wrap modulo 2^STAT_WIDTH.
- Back-to-back frames (tlast then b0 on the next cycle) must be handled with no lost beat.
- Reset asserted mid-frame: all state clears immediately; no key_valid is produced for that frame.

Decomposition:
- Package kvs_pkg holds:
  - KEY_SIZE, FLAG_SIZE.
  - Flag bit indices FLAG_TCP=0, FLAG_UDP=1, FLAG_SYN=2, FLAG_FINRST=3.
  - ETHERTYPE_IPV4=16'h0800, IP_PROTO_TCP=8'd6, IP_PROTO_UDP=8'd17.
  - typedef kvs_key_t packed struct {src_ip, dst_ip, sport, dport}.
- The database block and this block share the package.
- No sub-module. Counters are small enough to stay inline.

Test Plan:
- TCP SYN 64B frame, 10.0.0.1:1234 → 10.0.0.2:80 → one key_valid 1 cycle after b5, key_data=96'h0A000001_0A000002_04D2_0050, key_flag=4'b0101, stat_keys=1.
- UDP 60B frame, 192.168.1.5:53 → 192.168.1.9:4000, with tvalid gaps of 3 cycles between beats → key_data=96'hC0A80105_C0A80109_0035_0FA0, key_flag=4'b0010, latency unchanged relative to b5.
- ARP frame (ethertype 0x0806), 60B → no key_valid, stat_skipped=1, stat_frames=1.
- Truncated 32B frame (tlast on b3) immediately followed by a valid TCP ACK+FIN frame → first frame produces no key; second frame produces key_flag=4'b1001; stat_frames=2, stat_skipped=1.
- IPv4 fragment (MF=1) and IHL=6 frames → no key_valid, stat_skipped=2.
- rst pulled low during b4 of a TCP frame, released, then a clean UDP frame → no key for the first frame; UDP key correct; stats reflect only the post-reset frame (stat_frames=1).
